one_lane_arbiter: RTL and testbench

ONE_LANE_ARBITER -- requirements
Module: one_lane_arbiter

---
 rtl/one_lane_pkg.sv | 26 ++
 rtl/one_lane_timer.sv | 45 ++++
 rtl/one_lane_arbiter.sv | 120 ++++++++++++
 tb/tb_one_lane_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/one_lane_pkg.sv
// ============================================================================
// Module   : one_lane_pkg
// Brief    : Shared types and constants for the one-lane arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package one_lane_pkg;

    localparam int C_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_E = 2'd1,
        GRANT_W = 2'd2,
        CLEAR   = 2'd3
    } state_t;

    typedef enum logic {
        EAST = 1'b0,
        WEST = 1'b1
    } dir_t;

endpackage

`default_nettype wire

// File: rtl/one_lane_timer.sv
// ============================================================================
// Module   : one_lane_timer
// Brief    : Loadable down-counter with zero flag; times the all-clear interval.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module one_lane_timer
    import one_lane_pkg::*;
#(
    parameter int WIDTH = C_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/one_lane_arbiter.sv
// ============================================================================
// Module   : one_lane_arbiter
// Brief    : Two-sided shared-lane arbiter with all-clear gap between grants.
//            Optional forced release enabled by macro ONE_LANE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module one_lane_arbiter
    import one_lane_pkg::*;
#(
    parameter int CLEAR_CYC = 3,
    parameter int MAX_HOLD  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req_e,
    input  logic req_w,
    output logic gnt_e,
    output logic gnt_w,
    output logic clr,
    output logic idle
);

    // Timer is loaded with CLEAR_CYC-1 so the zero flag is seen in the last clear cycle.
    localparam logic [C_CNT_W-1:0] C_CLEAR_LOAD = C_CNT_W'(CLEAR_CYC - 1);
    localparam logic [C_CNT_W-1:0] C_HOLD_LAST  = C_CNT_W'(MAX_HOLD - 1);

    state_t             state_q,    state_d;
    dir_t               last_dir_q, last_dir_d;
    logic [C_CNT_W-1:0] hold_q,     hold_d;

    logic w_req_own;
    logic w_req_opp;
    logic w_hold_last;
    logic w_timeout;
    logic w_tmr_load;
    logic w_tmr_dec;
    logic w_tmr_zero;

    assign w_req_own   = (state_q == GRANT_E) ? req_e : req_w;
    assign w_req_opp   = (state_q == GRANT_E) ? req_w : req_e;
    assign w_hold_last = (hold_q == C_HOLD_LAST);

`ifdef ONE_LANE_TIMEOUT_EN
    assign w_timeout = w_hold_last && w_req_opp;
`else
    logic w_unused_hold;
    assign w_unused_hold = w_hold_last ^ w_req_opp;
    assign w_timeout     = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        hold_d     = '0;
        w_tmr_load = 1'b0;
        w_tmr_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_e && (!req_w || (last_dir_q == WEST))) begin
                    state_d    = GRANT_E;
                    last_dir_d = EAST;
                end else if (req_w) begin
                    state_d    = GRANT_W;
                    last_dir_d = WEST;
                end
            end
            GRANT_E, GRANT_W: begin
                if (!w_req_own || w_timeout) begin
                    state_d    = CLEAR;
                    w_tmr_load = 1'b1;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end else begin
                    hold_d = hold_q;
                end
            end
            CLEAR: begin
                if (w_tmr_zero) begin
                    state_d = IDLE;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_dir_q <= WEST;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            hold_q     <= hold_d;
        end
    end

    one_lane_timer #(
        .WIDTH (C_CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_tmr_load),
        .load_val_i (C_CLEAR_LOAD),
        .dec_i      (w_tmr_dec),
        .zero_o     (w_tmr_zero)
    );

    assign idle  = (state_q == IDLE);
    assign gnt_e = (state_q == GRANT_E);
    assign gnt_w = (state_q == GRANT_W);
    assign clr   = (state_q == CLEAR);

endmodule

`default_nettype wire

// File: tb/tb_one_lane_arbiter.sv
// ============================================================================
// Module   : tb_one_lane_arbiter
// Brief    : Self-checking bench for one_lane_arbiter (CLEAR_CYC=3, MAX_HOLD=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_one_lane_arbiter;

    localparam int CLEAR_CYC = 3;
    localparam int MAX_HOLD  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_e = 1'b0;
    logic req_w = 1'b0;
    logic gnt_e, gnt_w, clr, idle;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the lane, clear cycles still owed, grant length so far.
    int m_owner      = 0;   // 0 none, 1 east, 2 west
    int m_clear_left = 0;
    int m_len        = 0;
    bit m_last_w     = 1'b1;

    always #5 clk = ~clk;

    one_lane_arbiter #(
        .CLEAR_CYC (CLEAR_CYC),
        .MAX_HOLD  (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req_e (req_e),
        .req_w (req_w),
        .gnt_e (gnt_e),
        .gnt_w (gnt_w),
        .clr   (clr),
        .idle  (idle)
    );

    function automatic logic [3:0] model_out();
        if (m_clear_left > 0) return 4'b0010;
        if (m_owner == 1)     return 4'b1000;
        if (m_owner == 2)     return 4'b0100;
        return 4'b0001;
    endfunction

    function automatic logic [3:0] dut_out();
        return {gnt_e, gnt_w, clr, idle};
    endfunction

    task automatic model_edge(input logic re, input logic rw, input logic rr);
        bit mine, other, timeout_en;
`ifdef ONE_LANE_TIMEOUT_EN
        timeout_en = 1'b1;
`else
        timeout_en = 1'b0;
`endif
        if (rr) begin
            m_owner = 0; m_clear_left = 0; m_len = 0; m_last_w = 1'b1;
        end else if (m_clear_left > 0) begin
            m_clear_left--;
        end else if (m_owner == 0) begin
            if (re && rw)  m_owner = m_last_w ? 1 : 2;
            else if (re)   m_owner = 1;
            else if (rw)   m_owner = 2;
            if (m_owner != 0) begin
                m_last_w = (m_owner == 2);
                m_len    = 1;
            end
        end else begin
            mine  = (m_owner == 1) ? re : rw;
            other = (m_owner == 1) ? rw : re;
            if (!mine || (timeout_en && other && (m_len == MAX_HOLD))) begin
                m_owner      = 0;
                m_clear_left = CLEAR_CYC;
                m_len        = 0;
            end else begin
                m_len++;
            end
        end
    endtask

    task automatic step(input logic re, input logic rw, input logic rr);
        @(negedge clk);
        req_e = re;
        req_w = rw;
        rst   = rr;
        @(posedge clk);
        model_edge(re, rw, rr);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, (i < 2));
            n_tests++;
            if (dut_out() !== 4'b0001) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=0001", i, dut_out());
            end
        end
    endtask

    task automatic test_single_east();
        int g_cnt = 0, c_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step((i < 6), 1'b0, 1'b0);
            n_tests++;
            if (dut_out() !== model_out()) begin
                n_fail++;
                $display("FAIL single_model cyc=%0d got=%b exp=%b", i, dut_out(), model_out());
            end
            if (gnt_e) g_cnt++;
            if (clr)   c_cnt++;
        end
        n_tests++;
        if (g_cnt != 6 || c_cnt != CLEAR_CYC || idle !== 1'b1) begin
            n_fail++;
            $display("FAIL single_counts got gnt=%0d clr=%0d idle=%b exp gnt=6 clr=%0d idle=1",
                     g_cnt, c_cnt, idle, CLEAR_CYC);
        end
    endtask

    task automatic test_tie();
        int c_cnt = 0;
        bit got_w = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        n_tests++;
        if (dut_out() !== 4'b1000) begin
            n_fail++;
            $display("FAIL tie_first got=%b exp=1000", dut_out());
        end
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10 && !got_w; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (clr) c_cnt++;
            if (gnt_w) got_w = 1'b1;
        end
        n_tests++;
        if (!got_w || c_cnt != CLEAR_CYC) begin
            n_fail++;
            $display("FAIL tie_second got gnt_w=%0b clr=%0d exp gnt_w=1 clr=%0d", got_w, c_cnt, CLEAR_CYC);
        end
        for (int i = 0; i < 10 && !idle; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        n_tests++;
        if (dut_out() !== 4'b1000) begin
            n_fail++;
            $display("FAIL tie_third got=%b exp=1000", dut_out());
        end
    endtask

    task automatic test_timeout();
        int e_cnt = 0, c_cnt = 0;
        bit got_w = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        while (gnt_e && e_cnt < 40) begin
            e_cnt++;
            step(1'b1, 1'b1, 1'b0);
        end
`ifdef ONE_LANE_TIMEOUT_EN
        n_tests++;
        if (e_cnt != MAX_HOLD) begin
            n_fail++;
            $display("FAIL timeout_hold got=%0d exp=%0d", e_cnt, MAX_HOLD);
        end
        for (int i = 0; i < 10 && !got_w; i++) begin
            if (clr) c_cnt++;
            if (gnt_w) got_w = 1'b1;
            else step(1'b1, 1'b1, 1'b0);
        end
        n_tests++;
        if (!got_w || c_cnt != CLEAR_CYC) begin
            n_fail++;
            $display("FAIL timeout_handover got gnt_w=%0b clr=%0d exp gnt_w=1 clr=%0d", got_w, c_cnt, CLEAR_CYC);
        end
`else
        n_tests++;
        if (e_cnt != 40) begin
            n_fail++;
            $display("FAIL hold_no_timeout got=%0d exp=40", e_cnt);
        end
        step(1'b0, 1'b1, 1'b0);
        n_tests++;
        if (dut_out() !== 4'b0010) begin
            n_fail++;
            $display("FAIL hold_release got=%b exp=0010", dut_out());
        end
`endif
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_grant();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        n_tests++;
        if (dut_out() !== 4'b0100) begin
            n_fail++;
            $display("FAIL rst_mid_pre got=%b exp=0100", dut_out());
        end
        step(1'b1, 1'b1, 1'b1);
        n_tests++;
        if (dut_out() !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_mid_abort got=%b exp=0001", dut_out());
        end
        step(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (dut_out() !== 4'b1000) begin
            n_fail++;
            $display("FAIL rst_mid_regrant got=%b exp=1000", dut_out());
        end
    endtask

    task automatic test_random();
        logic re = 1'b0, rw = 1'b0, rr;
        int prev_side = 0, clr_run = 0;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(3) == 0) re = ~re;
            if ($urandom_range(3) == 0) rw = ~rw;
            rr = ($urandom_range(499) == 0);
            step(re, rw, rr);
            n_tests++;
            if (dut_out() !== model_out() || !$onehot(dut_out())) begin
                n_fail++;
                $display("FAIL random_model cyc=%0d got=%b exp=%b", i, dut_out(), model_out());
            end
            if (rr) begin
                prev_side = 0;
                clr_run   = 0;
            end else if (gnt_e || gnt_w) begin
                n_tests++;
                if (prev_side == (gnt_e ? 2 : 1) && clr_run < CLEAR_CYC) begin
                    n_fail++;
                    $display("FAIL random_gap cyc=%0d clr_between=%0d required>=%0d", i, clr_run, CLEAR_CYC);
                end
                prev_side = gnt_e ? 1 : 2;
                clr_run   = 0;
            end else if (clr) begin
                clr_run++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_east();
        test_tie();
        test_timeout();
        test_reset_mid_grant();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
